rng_arbiter: RTL and testbench
==============================

// Module: rng_arbiter
// PURPOSE
//  Owns the game's 10-bit Fibonacci LFSR (taps bit9^bit6, shift-left, LSB fill) and shares it
//  among NREQ requesters (block spawn x-position, drift speed, colour, ...). Round-robin
//  arbitration with req/ack handshake. Each delivered value is separated from the previous one by
//  at least MIN_SHIFTS LFSR shifts and is range-reduced to 0..LIMIT. Sits between the game FSM
//  clients and the drawing/physics logic.
// PARAMETERS
//  NREQ       3    number of requesters (2..8)
//  MIN_SHIFTS 10   minimum LFSR shifts between two deliveries (1..15)
//  LIMIT      600  max delivered value. Must satisfy 511 <= LIMIT <= 1022.
// PORTS
//  clk        in   1     system clock, all logic on rising edge
//  rst        in   1     asynchronous, active-low reset
//  req        in   NREQ  request per client; held high until its ack
//  seed_load  in   1     load seed into LFSR this cycle
//  seed       in   10    seed value
//  ack        out  NREQ  one-cycle grant/delivery pulse, at most one bit set
//  rnd_out    out  10    delivered value, valid only while any ack bit is high
//  busy       out  1     high in every state except IDLE
// BEHAVIOUR
//  Reset (rst=0, async): lfsr=10'h3FF, fresh_cnt=0, rr_ptr=0, state=IDLE, ack=0, rnd_out=0, busy=0.
//  LFSR
//   - Shifts every cycle: lfsr <= {lfsr[8:0], lfsr[9]^lfsr[6]}.
//   - seed_load overrides the shift that cycle: lfsr <= (seed==0) ? 10'h3FF : seed.
//   - seed_load also clears fresh_cnt.
//  Freshness counter
//   - fresh_cnt increments once per shift and saturates at MIN_SHIFTS.
//   - Cleared to 0 on each delivery and on each seed_load; seed_load wins over delivery.
//  Range reduction (combinational on the current lfsr)
//   - red = (lfsr > LIMIT) ? lfsr - (LIMIT+1) : lfsr.
//   - A single subtract suffices because LIMIT >= 511. Result is always 0..LIMIT.
//  FSM states: IDLE, GRANT, DELIVER.
//   - IDLE: if |req, pick the first set req bit at or after rr_ptr, wrapping modulo NREQ.
//     Register it as gnt_idx and go to GRANT. Otherwise stay in IDLE.
//   - GRANT: if req[gnt_idx] has dropped, return to IDLE with no ack; rr_ptr and fresh_cnt
//     are unchanged.
//     Else if fresh_cnt >= MIN_SHIFTS (sampled this cycle), go to DELIVER. Else stay in GRANT.
//   - DELIVER (exactly one cycle): ack[gnt_idx]=1 and rnd_out=red (registered from GRANT's
//     lfsr). Clear fresh_cnt, set rr_ptr <= (gnt_idx+1) mod NREQ, go to IDLE.
//  Outputs: ack and rnd_out are registered. rnd_out holds its last value between deliveries.
//  Latency: req sampled high in IDLE at edge t, with the counter already fresh -> ack high in
//   the cycle after edge t+2. Back-to-back deliveries are spaced by at least MIN_SHIFTS+1 cycles.
//  Requester rules
//   - Client must hold req until ack and must deassert it in the ack cycle, or be re-served
//     later as a new request.
//   - Requests from non-granted clients stay pending; there is no queue beyond the req level.
//  seed_load during GRANT or DELIVER: the delivery is not aborted. The freshness wait restarts,
//   so GRANT waits MIN_SHIFTS more shifts.
//  Reset mid-operation returns everything to reset values immediately. No ack is emitted.
// TESTING
//  1. Reset -> ack=0, rnd_out=0, busy=0. 12 cycles idle then req=3'b001 -> ack=001 two cycles
//     after sampling; rnd_out matches the reduced value of a bit-accurate LFSR model.
//  2. req=3'b111 held, each bit dropped on its ack -> ack order 001,010,100. Deliveries are
//     spaced MIN_SHIFTS+1=11 cycles apart.
//  3. Reduction: seed_load 10'd600, 10'd601, 10'd1023 with fresh_cnt forced stale ->
//     model-checked red values: 600->600, 601->0, 1023->422. All outputs <= 600.
//  4. seed=0 loaded -> lfsr becomes 10'h3FF, next shift 10'h3FE. seed_load while in GRANT
//     -> ack delayed by MIN_SHIFTS cycles after the load.
//  5. req[1] dropped while waiting in GRANT -> no ack, return to IDLE, rr_ptr unchanged.
//     A later req=3'b010 is served.
//  6. rst asserted low in GRANT and in DELIVER -> ack=0 at once, busy=0, lfsr=10'h3FF.
//     Test 1 behaviour repeats after release.

Source files
------------

// File: rtl/rng_arbiter.sv
// Shared 10-bit Fibonacci LFSR with round-robin req/ack arbitration.
// Each delivered value is range-reduced to 0..LIMIT and is separated from
// the previous delivery by at least MIN_SHIFTS shifts of the generator.
module rng_arbiter #(
  parameter int NREQ       = 3,
  parameter int MIN_SHIFTS = 10,
  parameter int LIMIT      = 600
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            seed_load,
  input  logic [9:0]      seed,
  output logic [NREQ-1:0] ack,
  output logic [9:0]      rnd_out,
  output logic            busy
);

  localparam int         IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] MIN_C  = 4'(MIN_SHIFTS);
  localparam logic [9:0] LIM_C  = 10'(LIMIT);
  localparam logic [9:0] LIM_P1 = 10'(LIMIT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, DELIVER} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic        [9:0]      lfsr;
  logic        [3:0]      fresh_cnt;
  logic        [IDX_W-1:0] rr_ptr;
  logic        [IDX_W-1:0] gnt_idx;
  logic        [IDX_W-1:0] pick_idx;
  logic        [IDX_W-1:0] cand_idx;
  logic                   pick_vld;
  logic                   fresh;
  logic                   take;
  logic                   deliver;
  logic        [9:0]      red_p1;
  int                     cand;

  // One Fibonacci step: shift left, feedback bit9 ^ bit6 into the LSB.
  function automatic logic [9:0] lfsr_step(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  // Single conditional subtract folds 0..1023 into 0..LIMIT since LIMIT >= 511.
  function automatic logic [9:0] reduce(input logic [9:0] v);
    return (v > LIM_C) ? (v - LIM_P1) : v;
  endfunction

  assign fresh = (fresh_cnt >= MIN_C);

  // Round-robin pick: first set request at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: a dropped request in GRANT abandons the grant silently.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_vld) state_nxt = GRANT;
      GRANT: begin
        if (!req[gnt_idx]) state_nxt = IDLE;
        else if (fresh)    state_nxt = DELIVER;
      end
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode: take captures the value, deliver pulses ack.
  always_comb begin
    busy    = (state != IDLE);
    take    = (state == GRANT) && req[gnt_idx] && fresh;
    deliver = (state == DELIVER);
  end

  // LFSR: free-running shift, seed load overrides; zero seed would lock up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           lfsr <= 10'h3FF;
    else if (seed_load) lfsr <= (seed == 10'd0) ? 10'h3FF : seed;
    else                lfsr <= lfsr_step(lfsr);
  end

  // Freshness counter: saturating shift count since last take or seed load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  fresh_cnt <= '0;
    else if (seed_load || take) fresh_cnt <= '0;
    else if (!fresh)           fresh_cnt <= fresh_cnt + 4'd1;
  end

  // Grant index latched on leaving IDLE; pointer advances past the served client.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_idx <= '0;
      rr_ptr  <= '0;
    end else begin
      if (state == IDLE && pick_vld) gnt_idx <= pick_idx;
      if (deliver) rr_ptr <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Capture stage: reduced value taken from the LFSR as seen in GRANT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      red_p1 <= '0;
    else if (take) red_p1 <= reduce(lfsr);
  end

  // Delivery stage: registered ack pulse with the held value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack     <= '0;
      rnd_out <= '0;
    end else begin
      ack <= '0;
      if (deliver) begin
        ack     <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
        rnd_out <= red_p1;
      end
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: transaction-level model plus directed scenarios.
module tb_rng_arbiter;

  localparam int NREQ       = 3;
  localparam int MIN_SHIFTS = 10;
  localparam int LIMIT      = 600;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req = 3'b000;
  logic       seed_load = 1'b0;
  logic [9:0] seed = 10'd0;
  logic [2:0] ack;
  logic [9:0] rnd_out;
  logic       busy;

  rng_arbiter #(.NREQ(NREQ), .MIN_SHIFTS(MIN_SHIFTS), .LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .req(req), .seed_load(seed_load), .seed(seed),
    .ack(ack), .rnd_out(rnd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int ack_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] m_shift(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  function automatic logic [9:0] m_pre(input logic [9:0] v);
    return {v[0] ^ v[7], v[9:1]};
  endfunction

  function automatic int m_red(input logic [9:0] v);
    int x;
    x = int'(v);
    return (x > LIMIT) ? x - (LIMIT + 1) : x;
  endfunction

  // Model: holder = client being served (-1 none), taken = value already
  // drawn for it (-1 not yet), age = shifts since last draw or seed load.
  logic [9:0] m_lfsr   = 10'h3FF;
  int         m_age    = 0;
  int         m_holder = -1;
  int         m_taken  = -1;
  int         m_next   = 0;
  int         m_idx;
  bit         m_took;
  logic [2:0] e_ack  = 3'b000;
  logic [9:0] e_rnd  = 10'd0;
  logic       e_busy = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_lfsr = 10'h3FF; m_age = 0; m_holder = -1; m_taken = -1; m_next = 0;
      e_ack = 3'b000; e_rnd = 10'd0; e_busy = 1'b0;
    end else begin
      cyc++;
      m_took = 1'b0;
      e_ack  = 3'b000;
      if (m_holder >= 0 && m_taken >= 0) begin
        e_ack    = 3'(1 << m_holder);
        e_rnd    = 10'(m_taken);
        m_next   = (m_holder + 1) % NREQ;
        m_holder = -1;
        m_taken  = -1;
      end else if (m_holder >= 0) begin
        if (!req[m_holder]) m_holder = -1;
        else if (m_age >= MIN_SHIFTS) begin
          m_taken = m_red(m_lfsr);
          m_took  = 1'b1;
        end
      end else if (req != 3'b000) begin
        for (int k = 0; k < NREQ; k++) begin
          m_idx = (m_next + k) % NREQ;
          if (m_holder < 0 && req[m_idx]) m_holder = m_idx;
        end
      end
      if (seed_load || m_took)      m_age = 0;
      else if (m_age < MIN_SHIFTS)  m_age++;
      m_lfsr = seed_load ? ((seed == 10'd0) ? 10'h3FF : seed) : m_shift(m_lfsr);
      e_busy = (m_holder >= 0);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("ack", {29'd0, ack}, {29'd0, e_ack});
    chk("rnd_out", {22'd0, rnd_out}, {22'd0, e_rnd});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("rnd_range", {31'd0, (rnd_out <= 10'(LIMIT))}, 32'd1);
    chk("ack_onehot", {31'd0, ($countones(ack) <= 1)}, 32'd1);
    if (ack != 3'b000) ack_count++;
  end

  // Clients drop their request in the ack cycle.
  initial forever begin
    @(posedge clk);
    #2;
    req = req & ~ack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int maxc, output int gc, output logic [2:0] ga,
                          output logic [9:0] gr);
    gc = -1; ga = 3'b000; gr = 10'd0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        gc = cyc; ga = ack; gr = rnd_out;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL ack_timeout: got no ack within %0d cycles, required one", maxc);
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got no completion, required finish before 100000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  int         c0, c1, gc, n0;
  int         cy[3];
  logic [2:0] ga;
  logic [9:0] gr, r1, s, v;
  int         lits[3];
  logic [9:0] targ[3];

  initial begin
    // Literal pins on the model itself.
    chk("model_shift_3ff", {22'd0, m_shift(10'h3FF)}, 32'h3FE);
    chk("model_red_600", m_red(10'd600), 32'd600);
    chk("model_red_601", m_red(10'd601), 32'd0);
    chk("model_red_1023", m_red(10'd1023), 32'd422);

    // Test 1: reset values, then a single request after 12 idle cycles.
    #1;
    chk("rst_ack", {29'd0, ack}, 32'd0);
    chk("rst_rnd", {22'd0, rnd_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step(); step();
    rst = 1'b1;
    repeat (12) step();
    req = 3'b001; c0 = cyc;
    wait_ack(20, gc, ga, gr);
    chk("t1_latency", gc, c0 + 3);
    chk("t1_ack", {29'd0, ga}, 32'd1);
    r1 = gr;

    // Test 2: all three request from a fresh reset; round-robin order and spacing.
    step(); rst = 1'b0; step(); rst = 1'b1;
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_ack(40, gc, ga, gr);
      cy[k] = gc;
      chk("t2_order", {29'd0, ga}, 32'(1 << k));
    end
    chk("t2_space01", cy[1] - cy[0], MIN_SHIFTS + 1);
    chk("t2_space12", cy[2] - cy[1], MIN_SHIFTS + 1);

    // Test 3: seeds chosen so the drawn LFSR value is exactly 600, 601, 1023.
    targ[0] = 10'd600;  lits[0] = 600;
    targ[1] = 10'd601;  lits[1] = 0;
    targ[2] = 10'd1023; lits[2] = 422;
    for (int k = 0; k < 3; k++) begin
      v = targ[k];
      for (int j = 0; j < MIN_SHIFTS; j++) v = m_pre(v);
      s = v;
      step();
      seed = s; seed_load = 1'b1; req = 3'b001; c0 = cyc;
      step();
      seed_load = 1'b0;
      wait_ack(30, gc, ga, gr);
      chk("t3_latency", gc, c0 + MIN_SHIFTS + 3);
      chk("t3_ack", {29'd0, ga}, 32'd1);
      chk("t3_red", {22'd0, gr}, 32'(lits[k]));
    end

    // Test 4a: zero seed behaves as 3FF.
    v = 10'h3FF;
    for (int j = 0; j < MIN_SHIFTS; j++) v = m_shift(v);
    step();
    seed = 10'd0; seed_load = 1'b1; req = 3'b001;
    step();
    seed_load = 1'b0;
    wait_ack(30, gc, ga, gr);
    chk("t4_zero_seed", {22'd0, gr}, 32'(m_red(v)));

    // Test 4b: seed load while waiting in GRANT restarts the freshness wait.
    step();
    req = 3'b010;
    repeat (4) step();
    step();
    seed = 10'h155; seed_load = 1'b1; c1 = cyc;
    step();
    seed_load = 1'b0;
    wait_ack(30, gc, ga, gr);
    chk("t4_reload_latency", gc, c1 + MIN_SHIFTS + 3);
    chk("t4_reload_ack", {29'd0, ga}, 32'd2);

    // Test 5: request withdrawn in GRANT gives no ack; a later one is served.
    step();
    req = 3'b010;
    repeat (3) step();
    req = 3'b000; n0 = ack_count;
    repeat (15) step();
    chk("t5_no_ack", ack_count, n0);
    chk("t5_idle", {31'd0, busy}, 32'd0);
    req = 3'b010;
    wait_ack(30, gc, ga, gr);
    chk("t5_served", {29'd0, ga}, 32'd2);

    // Test 6a: reset while in GRANT.
    step();
    req = 3'b001;
    step(); step();
    rst = 1'b0; req = 3'b000;
    #1;
    chk("t6g_ack", {29'd0, ack}, 32'd0);
    chk("t6g_busy", {31'd0, busy}, 32'd0);
    chk("t6g_rnd", {22'd0, rnd_out}, 32'd0);
    step();
    rst = 1'b1;

    // Test 6b: reset in the DELIVER cycle suppresses the ack.
    repeat (12) step();
    req = 3'b001; n0 = ack_count;
    step(); step();
    rst = 1'b0; req = 3'b000;
    #1;
    chk("t6d_ack", {29'd0, ack}, 32'd0);
    chk("t6d_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b1;
    chk("t6d_no_ack", ack_count, n0);

    // Test 6c: after release the first-test behaviour repeats exactly.
    repeat (12) step();
    req = 3'b001; c0 = cyc;
    wait_ack(20, gc, ga, gr);
    chk("t6_latency", gc, c0 + 3);
    chk("t6_ack", {29'd0, ga}, 32'd1);
    chk("t6_repeat_rnd", {22'd0, gr}, {22'd0, r1});

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
